seg_scan_decoder: RTL and testbench

- Receive-side counterpart of the multiplexed 7-segment display driver: samples seg/dp/digit-enable lines and reconstructs the digit values being shown.
- Used for on-chip loopback self-test and board-level readback of the 12-hour clock display.
- Outputs a coherent snapshot of all digits, updated once per complete scan frame, plus error flags.

---
 rtl/seg_scan_decoder.sv | 203 ++++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// Receive-side decoder for a multiplexed 7-segment display: samples the scan lines,
// captures each stable digit window and publishes a coherent per-frame snapshot.
module seg_scan_decoder #(
   parameter int NUM_DIGITS     = 8,
   parameter bit SEG_ACTIVE_LOW = 1'b0,
   parameter bit EN_ACTIVE_LOW  = 1'b0,
   parameter int SETTLE_CYCLES  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [6:0]            seg_in,
   input  logic                  dp_in,
   input  logic [NUM_DIGITS-1:0] disp_en_in,
   input  logic [2:0]            digit_sel,
   output logic [3:0]            digit_out,
   output logic                  dp_out,
   output logic                  frame_done,
   output logic                  err_sticky,
   input  logic                  clr_err
);

   localparam int W = 8 + NUM_DIGITS;
   localparam logic [3:0] S = 4'(SETTLE_CYCLES);
   localparam logic [W-1:0] INV = {{NUM_DIGITS{EN_ACTIVE_LOW}}, {8{SEG_ACTIVE_LOW}}};

   typedef enum logic [1:0] {ST_WAIT, ST_SETTLE, ST_HOLD} state_t;

   logic [W-1:0]            sync1, sync2, cur, prev;
   logic [6:0]              seg;
   logic                    dp;
   logic [NUM_DIGITS-1:0]   en;
   logic                    changed, en_ok, multi;
   logic [2:0]              idx;
   logic [3:0]              ones;
   state_t                  state;
   logic [3:0]              cnt, cnt_inc, mh_cnt, mh_inc;
   logic                    capture, mh_set, full;
   logic [3:0]              dec;
   logic [NUM_DIGITS-1:0]   mask;
   logic [3:0]              work [0:7];
   logic                    work_dp [0:7];
   logic [3:0]              snap [0:7];
   logic                    snap_dp [0:7];

   // Polarity is normalized after the synchronizer so every bit sees identical latency.
   assign cur     = sync2 ^ INV;
   assign seg     = cur[6:0];
   assign dp      = cur[7];
   assign en      = cur[W-1:8];
   assign changed = (cur != prev);
   assign cnt_inc = cnt + 4'd1;
   assign mh_inc  = mh_cnt + 4'd1;
   assign full    = &mask;

   always_comb begin
      idx  = 3'd0;
      ones = 4'd0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (en[i]) begin
            idx  = 3'(i);
            ones = ones + 4'd1;
         end
      end
   end

   assign en_ok = (ones == 4'd1);
   assign multi = (ones >= 4'd2);

   always_comb begin
      case (seg)
         7'h3F:   dec = 4'd0;
         7'h06:   dec = 4'd1;
         7'h5B:   dec = 4'd2;
         7'h4F:   dec = 4'd3;
         7'h66:   dec = 4'd4;
         7'h6D:   dec = 4'd5;
         7'h7D:   dec = 4'd6;
         7'h07:   dec = 4'd7;
         7'h7F:   dec = 4'd8;
         7'h6F:   dec = 4'd9;
         7'h00:   dec = 4'hF;
         default: dec = 4'hE;
      endcase
   end

   // A window's first stable sample counts as 1, so capture fires on sample SETTLE_CYCLES.
   always_comb begin
      capture = 1'b0;
      case (state)
         ST_WAIT:   capture = en_ok && (S == 4'd1);
         ST_SETTLE: capture = !changed && en_ok && (cnt_inc == S);
         ST_HOLD:   capture = changed && en_ok && (S == 4'd1);
         default:   capture = 1'b0;
      endcase
   end

   always_comb begin
      mh_set = 1'b0;
      if (multi) begin
         if (changed || mh_cnt == 4'd0) mh_set = (S == 4'd1);
         else                           mh_set = (mh_cnt != S) && (mh_inc == S);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
         prev  <= '0;
      end else begin
         sync1 <= {disp_en_in, dp_in, seg_in};
         sync2 <= sync1;
         prev  <= cur;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_WAIT;
         cnt   <= 4'd0;
      end else begin
         case (state)
            ST_WAIT: begin
               if (en_ok) begin
                  cnt   <= 4'd1;
                  state <= (S == 4'd1) ? ST_HOLD : ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (changed || !en_ok) begin
                  cnt   <= 4'd0;
                  state <= ST_WAIT;
               end else begin
                  cnt <= cnt_inc;
                  if (cnt_inc == S) state <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (changed) begin
                  if (!en_ok) begin
                     cnt   <= 4'd0;
                     state <= ST_WAIT;
                  end else begin
                     cnt   <= 4'd1;
                     state <= (S == 4'd1) ? ST_HOLD : ST_SETTLE;
                  end
               end
            end
            default: begin
               cnt   <= 4'd0;
               state <= ST_WAIT;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mh_cnt <= 4'd0;
      end else if (!multi) begin
         mh_cnt <= 4'd0;
      end else if (changed || mh_cnt == 4'd0) begin
         mh_cnt <= 4'd1;
      end else if (mh_cnt != S) begin
         mh_cnt <= mh_inc;
      end
   end

   // Snapshot copies the pre-edge work array, so a capture landing on the same edge
   // belongs to the next frame and re-seeds the freshly cleared mask.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mask       <= '0;
         frame_done <= 1'b0;
         err_sticky <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            work[i]    <= 4'hF;
            work_dp[i] <= 1'b0;
            snap[i]    <= 4'hF;
            snap_dp[i] <= 1'b0;
         end
      end else begin
         frame_done <= full;
         if (full) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
               snap[i]    <= work[i];
               snap_dp[i] <= work_dp[i];
            end
         end
         mask <= (full ? '0 : mask) | (capture ? en : '0);
         if (capture) begin
            work[idx]    <= dec;
            work_dp[idx] <= dp;
         end
         if (clr_err)                                     err_sticky <= 1'b0;
         else if ((capture && dec == 4'hE) || mh_set)     err_sticky <= 1'b1;
      end
   end

   assign digit_out = snap[digit_sel];
   assign dp_out    = snap_dp[digit_sel];

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed scan frames plus random digit windows, checked
// against a window-level reference model; a second instance sees the inverted lines.
module tb_seg_scan_decoder;

   localparam int SETTLE = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] seg;
   logic       dp;
   logic [7:0] en;
   logic [2:0] sel;
   logic       clr;
   logic [6:0] seg_n;
   logic       dp_n;
   logic [7:0] en_n;
   logic [3:0] dout, dout_p;
   logic       dpo, dpo_p, fd, fd_p, err, err_p;

   int n_checks = 0;
   int n_fail   = 0;
   int fd_cnt   = 0;
   int fd_cnt_p = 0;

   assign seg_n = ~seg;
   assign dp_n  = ~dp;
   assign en_n  = ~en;

   always #5 clk = ~clk;

   seg_scan_decoder #(.NUM_DIGITS(8), .SEG_ACTIVE_LOW(1'b0), .EN_ACTIVE_LOW(1'b0),
                      .SETTLE_CYCLES(SETTLE)) dut (
      .clk(clk), .rst_n(rst_n), .seg_in(seg), .dp_in(dp), .disp_en_in(en),
      .digit_sel(sel), .digit_out(dout), .dp_out(dpo), .frame_done(fd),
      .err_sticky(err), .clr_err(clr));

   seg_scan_decoder #(.NUM_DIGITS(8), .SEG_ACTIVE_LOW(1'b1), .EN_ACTIVE_LOW(1'b1),
                      .SETTLE_CYCLES(SETTLE)) dut_pol (
      .clk(clk), .rst_n(rst_n), .seg_in(seg_n), .dp_in(dp_n), .disp_en_in(en_n),
      .digit_sel(sel), .digit_out(dout_p), .dp_out(dpo_p), .frame_done(fd_p),
      .err_sticky(err_p), .clr_err(clr));

   always @(negedge clk) begin
      if (fd)   fd_cnt   <= fd_cnt + 1;
      if (fd_p) fd_cnt_p <= fd_cnt_p + 1;
   end

   // ---------------- reference model ----------------
   logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
   logic [6:0] bad_tab [3]  = '{7'h49, 7'h01, 7'h7E};
   logic [3:0] m_work [8];
   logic       m_wdp  [8];
   logic [3:0] m_snap [8];
   logic       m_sdp  [8];
   logic [7:0] m_mask;
   int         m_frames = 0;
   logic       m_err;

   function automatic logic [3:0] ref_decode(input logic [6:0] s);
      if (s == 7'h00) return 4'hF;
      for (int i = 0; i < 10; i++) if (seg_tab[i] == s) return 4'(i);
      return 4'hE;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         m_work[i] = 4'hF; m_wdp[i] = 1'b0; m_snap[i] = 4'hF; m_sdp[i] = 1'b0;
      end
      m_mask = 8'h00;
      m_err  = 1'b0;
   endtask

   // A window held for at least SETTLE cycles is seen exactly once.
   task automatic model_window(input logic [7:0] e, input logic [6:0] s, input logic d,
                               input int len);
      int idx;
      logic [3:0] v;
      if (len < SETTLE) return;
      if ($countones(e) == 1) begin
         idx = 0;
         for (int i = 0; i < 8; i++) if (e[i]) idx = i;
         v = ref_decode(s);
         m_work[idx] = v;
         m_wdp[idx]  = d;
         m_mask[idx] = 1'b1;
         if (v == 4'hE) m_err = 1'b1;
         if (m_mask == 8'hFF) begin
            for (int i = 0; i < 8; i++) begin
               m_snap[i] = m_work[i]; m_sdp[i] = m_wdp[i];
            end
            m_frames++;
            m_mask = 8'h00;
         end
      end else if ($countones(e) >= 2) begin
         m_err = 1'b1;
      end
   endtask

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_now();
      check("frame_done_idle", 32'(fd), 32'(0));
      check("frame_done_idle_pol", 32'(fd_p), 32'(0));
      check("frames", 32'(fd_cnt), 32'(m_frames));
      check("frames_pol", 32'(fd_cnt_p), 32'(m_frames));
      check("err", 32'(err), 32'(m_err));
      check("err_pol", 32'(err_p), 32'(m_err));
      for (int i = 0; i < 8; i++) begin
         sel = 3'(i);
         #1;
         check($sformatf("digit%0d", i), 32'(dout), 32'(m_snap[i]));
         check($sformatf("dp%0d", i), 32'(dpo), 32'(m_sdp[i]));
         check($sformatf("digit%0d_pol", i), 32'(dout_p), 32'(m_snap[i]));
         check($sformatf("dp%0d_pol", i), 32'(dpo_p), 32'(m_sdp[i]));
      end
   endtask

   task automatic check_all();
      repeat (8) @(posedge clk);
      #1;
      check_now();
   endtask

   // ---------------- drivers ----------------
   task automatic drive_window(input logic [7:0] e, input logic [6:0] s, input logic d,
                               input int len, input int gap);
      @(posedge clk); #1;
      en = e; seg = s; dp = d;
      repeat (len) @(posedge clk);
      #1;
      en = 8'h00; seg = 7'h00; dp = 1'b0;
      model_window(e, s, d, len);
      repeat (gap) @(posedge clk);
   endtask

   task automatic do_clear();
      @(posedge clk); #1; clr = 1'b1;
      @(posedge clk); #1; clr = 1'b0;
      m_err = 1'b0;
   endtask

   task automatic do_frame(input int v0, input int v1, input int v2, input int v3,
                           input int v4, input int v5, input int v6, input int v7);
      int vals [8];
      vals = '{v0, v1, v2, v3, v4, v5, v6, v7};
      for (int i = 0; i < 8; i++) drive_window(8'(1 << i), seg_tab[vals[i]], 1'b0, 10, 2);
   endtask

   initial begin
      logic [7:0] e;
      logic [6:0] s;
      int r, a, b;
      rst_n = 1'b0; seg = 7'h00; dp = 1'b0; en = 8'h00; sel = 3'd0; clr = 1'b0;
      model_reset();

      // Reset held with random activity on the lines.
      repeat (6) begin
         @(posedge clk); #1;
         seg = 7'($urandom); dp = 1'($urandom); en = 8'($urandom);
      end
      check_now();
      en = 8'h00; seg = 7'h00; dp = 1'b0;
      @(posedge clk); #1; rst_n = 1'b1;
      repeat (20) @(posedge clk);
      check_all();

      // Nominal frame, dp on digit 1 only.
      for (int i = 0; i < 8; i++) begin
         a = (i == 0) ? 1 : (i == 1) ? 2 : (i == 2) ? 3 : (i == 3) ? 4 :
             (i == 4) ? 5 : (i == 5) ? 9 : (i == 6) ? 0 : 8;
         drive_window(8'(1 << i), seg_tab[a], (i == 1), 10, 2);
      end
      check_all();

      // Settle boundary on digit 3: 3 cycles ignored, 4 captured.
      drive_window(8'h01, seg_tab[7], 1'b0, 10, 2);
      drive_window(8'h02, seg_tab[6], 1'b0, 10, 2);
      drive_window(8'h04, seg_tab[5], 1'b0, 10, 2);
      drive_window(8'h10, seg_tab[3], 1'b0, 10, 2);
      drive_window(8'h20, seg_tab[2], 1'b0, 10, 2);
      drive_window(8'h40, seg_tab[1], 1'b0, 10, 2);
      drive_window(8'h80, seg_tab[0], 1'b0, 10, 2);
      drive_window(8'h08, 7'h4F, 1'b0, SETTLE - 1, 2);
      check_all();
      drive_window(8'h08, 7'h4F, 1'b0, SETTLE, 2);
      check_all();

      // Multi-hot enable: error, no capture; then clear.
      drive_window(8'h03, seg_tab[5], 1'b0, 20, 2);
      check_all();
      do_clear();
      check_all();
      for (int i = 2; i < 8; i++) drive_window(8'(1 << i), seg_tab[i], 1'b0, 10, 2);
      check_all();
      drive_window(8'h01, seg_tab[8], 1'b1, 10, 2);
      drive_window(8'h02, seg_tab[9], 1'b0, 10, 2);
      check_all();

      // Undecodable pattern on digit 2.
      for (int i = 0; i < 8; i++)
         drive_window(8'(1 << i), (i == 2) ? 7'h49 : seg_tab[i], 1'b0, 10, 2);
      check_all();
      do_clear();

      // Partial frame discarded by reset.
      for (int i = 0; i < 6; i++) drive_window(8'(1 << i), seg_tab[7], 1'b0, 10, 2);
      @(posedge clk); #1; rst_n = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1; rst_n = 1'b1;
      check_all();
      do_frame(7, 7, 7, 7, 7, 7, 7, 7);
      check_all();

      // Digit 0 showing 5 (the active-low instance sees ~0x6D / ~0x01).
      do_frame(5, 1, 2, 3, 4, 6, 8, 0);
      check_all();

      // Random windows, some short, blank, multi-hot or undecodable.
      for (int n = 0; n < 80; n++) begin
         r = $urandom_range(0, 9);
         if (r == 0) begin
            a = $urandom_range(0, 7);
            b = (a + $urandom_range(1, 7)) % 8;
            e = 8'(1 << a) | 8'(1 << b);
         end else begin
            e = 8'(1 << $urandom_range(0, 7));
         end
         r = $urandom_range(0, 13);
         if (r < 10)       s = seg_tab[r];
         else if (r == 10) s = 7'h00;
         else              s = bad_tab[r - 11];
         drive_window(e, s, 1'($urandom), $urandom_range(1, 9), $urandom_range(1, 3));
         if (n % 8 == 7) begin
            check_all();
            if ($urandom_range(0, 1) == 1) do_clear();
         end
      end
      check_all();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
